// File: rtl/alu16_sequencer.sv
// alu16_sequencer: request/response front end for the multi-cycle alu16 datapath.
// Latches one operation at a time, pulses alu_on for a single cycle, waits the
// fixed ALU latency, captures alu_out and offers it on a valid/ready response port.
// Every output is a flop, so downstream logic sees glitch-free levels.

module alu16_sequencer #(
    parameter int         LATENCY   = 16,
    parameter logic [3:0] EXP_COUNT = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [2:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [16:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        alu_on,
    output logic [15:0] alu_ina,
    output logic [15:0] alu_inb,
    output logic [2:0]  alu_op,
    input  logic [16:0] alu_out,
    input  logic [3:0]  alu_count
);

    // Counter is sized to hold LATENCY-1; LATENCY >= 2 keeps the width non-zero.
    localparam int            CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Next values of the registered outputs.
    logic          req_ready_next;
    logic          rsp_valid_next;
    logic [16:0]   rsp_data_next;
    logic          rsp_err_next;
    logic          busy_next;
    logic          alu_on_next;
    logic [15:0]   alu_ina_next;
    logic [15:0]   alu_inb_next;
    logic [2:0]    alu_op_next;

    // State, step counter and all outputs are registered together; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 17'h0_0000;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            alu_on    <= 1'b0;
            alu_ina   <= 16'h0000;
            alu_inb   <= 16'h0000;
            alu_op    <= 3'b000;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            req_ready <= req_ready_next;
            rsp_valid <= rsp_valid_next;
            rsp_data  <= rsp_data_next;
            rsp_err   <= rsp_err_next;
            busy      <= busy_next;
            alu_on    <= alu_on_next;
            alu_ina   <= alu_ina_next;
            alu_inb   <= alu_inb_next;
            alu_op    <= alu_op_next;
        end
    end

    // Next-state and next-output decode; everything holds unless a transition changes it.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        req_ready_next = req_ready;
        rsp_valid_next = rsp_valid;
        rsp_data_next  = rsp_data;
        rsp_err_next   = rsp_err;
        busy_next      = busy;
        alu_on_next    = 1'b0;
        alu_ina_next   = alu_ina;
        alu_inb_next   = alu_inb;
        alu_op_next    = alu_op;

        case (state)
            IDLE: begin
                // Operands are captured only here, so req_* wiggling while busy is harmless.
                if (req_valid && req_ready) begin
                    alu_ina_next   = req_a;
                    alu_inb_next   = req_b;
                    alu_op_next    = req_op;
                    alu_on_next    = 1'b1;
                    req_ready_next = 1'b0;
                    busy_next      = 1'b1;
                    state_next     = LAUNCH;
                end else begin
                    state_next = IDLE;
                end
            end

            LAUNCH: begin
                // alu_on is high for this one cycle only; it falls at the edge that leaves LAUNCH.
                alu_on_next = 1'b0;
                cnt_next    = '0;
                state_next  = RUN;
            end

            RUN: begin
                if (cnt == CNT_LAST) begin
                    rsp_data_next  = alu_out;
                    rsp_err_next   = (alu_count != EXP_COUNT);
                    rsp_valid_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = RESP;
                end else begin
                    cnt_next   = cnt + CW'(1);
                    state_next = RUN;
                end
            end

            RESP: begin
                // No bypass: req_ready only returns after the response handshake edge.
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    req_ready_next = 1'b1;
                    busy_next      = 1'b0;
                    state_next     = IDLE;
                end else begin
                    state_next = RESP;
                end
            end

            default: begin
                // Unreachable encoding: fall back to the idle/reset output levels.
                state_next     = IDLE;
                cnt_next       = '0;
                req_ready_next = 1'b1;
                rsp_valid_next = 1'b0;
                busy_next      = 1'b0;
                alu_on_next    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Scoreboard bench for alu16_sequencer with a stub alu16 that presents a valid
// result (and the expected step count) only in the cycle before the capture edge.

module tb_alu16_sequencer;

    localparam int         LATENCY   = 16;
    localparam logic [3:0] EXP_COUNT = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;
    logic [2:0]  req_op = 3'b000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [16:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        alu_on;
    logic [15:0] alu_ina;
    logic [15:0] alu_inb;
    logic [2:0]  alu_op;
    logic [16:0] alu_out;
    logic [3:0]  alu_count;

    logic bad_count = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    typedef struct packed {
        logic [16:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    alu16_sequencer #(.LATENCY(LATENCY), .EXP_COUNT(EXP_COUNT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .alu_on(alu_on), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_op(alu_op),
        .alu_out(alu_out), .alu_count(alu_count)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to time accept and response edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Stub ALU behaviour.
    function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op);
        case (op)
            3'b000:  alu_model = {1'b0, a} + {1'b0, b};
            3'b001:  alu_model = {1'b0, a} - {1'b0, b};
            3'b010:  alu_model = {1'b0, a & b};
            3'b011:  alu_model = {1'b0, a | b};
            3'b100:  alu_model = {1'b0, a ^ b};
            3'b101:  alu_model = {a, 1'b0};
            3'b110:  alu_model = {2'b00, a[15:1]};
            default: alu_model = {1'b0, b};
        endcase
    endfunction

    logic stub_run;
    int   stub_steps;

    // Stub step counter: starts at the edge that samples alu_on.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_run   <= 1'b0;
            stub_steps <= 0;
        end else if (alu_on) begin
            stub_run   <= 1'b1;
            stub_steps <= 0;
        end else if (stub_run) begin
            if (stub_steps == LATENCY - 1) stub_run <= 1'b0;
            stub_steps <= stub_steps + 1;
        end
    end

    wire stub_done = stub_run && (stub_steps == LATENCY - 1);
    assign alu_out   = stub_done ? alu_model(alu_ina, alu_inb, alu_op) : 17'h1_5A5A;
    assign alu_count = stub_done ? (bad_count ? 4'h3 : EXP_COUNT) : 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_data), 32'h0);
                check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    logic prev_on = 1'b0;

    // alu_on must never stay high for two consecutive cycles.
    always @(negedge clk) begin
        if (alu_on) check("alu_on_pulse_width", 32'(prev_on), 32'h0);
        prev_on <= alu_on;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; returns the accept edge number.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic [16:0] exp_data, input logic exp_err, input logic push,
                         output int acc);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        check("req_ready_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_op = op;
        if (push) sb.push_back('{data: exp_data, err: exp_err});
        step();
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rise);
        int n;
        n = 0;
        while (!rsp_valid && n < 60) begin
            step();
            n++;
        end
        check("rsp_valid_timeout", 32'(rsp_valid), 32'h1);
        rise = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        check("drain_scoreboard", 32'(sb.size()), 32'h0);
        check("drain_idle", 32'(busy), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_alu_on"}, 32'(alu_on), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_alu_ops"}, {13'h0, alu_op, alu_ina}, 32'h0);
        check({tag, "_alu_inb"}, 32'(alu_inb), 32'h0);
        check({tag, "_rsp"}, {14'h0, rsp_err, rsp_data}, 32'h0);
    endtask

    int acc;
    int rise;
    int prev_acc;

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // 1: basic add with latency check
        rsp_ready = 1'b1;
        issue(16'h0007, 16'h0001, 3'b000, 17'h0_0008, 1'b0, 1'b1, acc);
        check("t1_alu_on_launch", 32'(alu_on), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        step();
        check("t1_alu_on_after", 32'(alu_on), 32'h0);
        wait_rsp(rise);
        check("t1_latency", 32'(rise - acc), 32'(LATENCY + 1));
        step();
        check("t1_req_ready_after_hs", 32'(req_ready), 32'h1);
        check("t1_rsp_valid_after_hs", 32'(rsp_valid), 32'h0);
        check("t1_busy_after_hs", 32'(busy), 32'h0);

        // 2: backpressure for 10 cycles
        rsp_ready = 1'b0;
        issue(16'h1234, 16'h0F0F, 3'b010, 17'h0_0204, 1'b0, 1'b1, acc);
        wait_rsp(rise);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_data", 32'(rsp_data), 32'h0_0204);
            check("t2_hold_err", 32'(rsp_err), 32'h0);
            check("t2_hold_ready_busy", {30'h0, req_ready, busy}, 32'h1);
            check("t2_hold_valid", 32'(rsp_valid), 32'h1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("t2_released_busy", 32'(busy), 32'h0);
        check("t2_released_ready", 32'(req_ready), 32'h1);

        // 3: operand hold while req_* changes; second request waits until after RESP
        issue(16'h00FF, 16'h0001, 3'b001, 17'h0_00FE, 1'b0, 1'b1, acc);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 60) begin
                req_valid = 1'b1;
                req_a = 16'($urandom);
                req_b = 16'($urandom);
                req_op = 3'($urandom);
                step();
                check("t3_hold_a", 32'(alu_ina), 32'h00FF);
                check("t3_hold_b_op", {13'h0, alu_op, alu_inb}, {13'h0, 3'b001, 16'h0001});
                check("t3_no_accept", 32'(req_ready), 32'h0);
                n++;
            end
        end
        req_a = 16'h0003;
        req_b = 16'h0005;
        req_op = 3'b011;
        sb.push_back('{data: 17'h0_0007, err: 1'b0});
        step();
        check("t3_not_accepted_at_hs", 32'(alu_ina), 32'h00FF);
        check("t3_ready_after_hs", 32'(req_ready), 32'h1);
        step();
        req_valid = 1'b0;
        check("t3_second_accept_a", 32'(alu_ina), 32'h0003);
        check("t3_second_alu_on", 32'(alu_on), 32'h1);
        drain();

        // 4: count mismatch still delivers data
        bad_count = 1'b1;
        issue(16'h8000, 16'h8000, 3'b000, 17'h1_0000, 1'b1, 1'b1, acc);
        drain();
        bad_count = 1'b0;

        // 5a: reset mid-RUN at cnt=8
        issue(16'h4444, 16'h1111, 3'b000, 17'h0_5555, 1'b0, 1'b0, acc);
        repeat (9) step();
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t5_run_reset");
        #2 rst = 1'b0;
        step();
        // 5b: reset while alu_on is high in LAUNCH
        issue(16'h2222, 16'h3333, 3'b100, 17'h0_1111, 1'b0, 1'b0, acc);
        check("t5_launch_alu_on", 32'(alu_on), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t5_launch_reset");
        #2 rst = 1'b0;
        for (int i = 0; i < LATENCY + 6; i++) begin
            step();
            check("t5_no_rsp", 32'(rsp_valid), 32'h0);
        end
        issue(16'hFFFF, 16'h0001, 3'b000, 17'h1_0000, 1'b0, 1'b1, acc);
        drain();

        // 6: four back-to-back requests, accept edges LATENCY+3 apart
        begin
            logic [15:0] va [4];
            logic [15:0] vb [4];
            logic [2:0]  vo [4];
            logic [16:0] ve [4];
            va[0] = 16'hAAAA; vb[0] = 16'h5555; vo[0] = 3'b100; ve[0] = 17'h0_FFFF;
            va[1] = 16'h8001; vb[1] = 16'h0000; vo[1] = 3'b101; ve[1] = 17'h1_0002;
            va[2] = 16'h0001; vb[2] = 16'h0002; vo[2] = 3'b001; ve[2] = 17'h1_FFFF;
            va[3] = 16'h0010; vb[3] = 16'h1357; vo[3] = 3'b111; ve[3] = 17'h0_1357;
            prev_acc = 0;
            for (int k = 0; k < 4; k++) begin
                int n;
                req_valid = 1'b1;
                req_a = va[k];
                req_b = vb[k];
                req_op = vo[k];
                sb.push_back('{data: ve[k], err: 1'b0});
                n = 0;
                while (!req_ready && n < 60) begin
                    step();
                    n++;
                end
                check("t6_ready_timeout", 32'(req_ready), 32'h1);
                step();
                check("t6_accept_a", 32'(alu_ina), 32'(va[k]));
                if (k > 0) check("t6_spacing", 32'(cyc - prev_acc), 32'(LATENCY + 3));
                prev_acc = cyc;
            end
            req_valid = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
